xbar_crosspoint: RTL and testbench
==================================

XBAR_CROSSPOINT -- requirements
Module: xbar_crosspoint

Interface
REQ-001 Parameters SHALL be:
  ADDR_W  32  address width
  DATA_W  32  write/read data width
  TMO_CYC  64  out_ack wait limit in cycles (>=2), used only with the timeout feature
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock
  reset  in  1  reset, synchronous, active-low
  en  in  1  column enable; 0 freezes FSM and timeout counter
  grant  in  1  arbiter grant for this crosspoint
  in_req  in  1  initiator request
  in_addr  in  ADDR_W  initiator address
  in_cmd  in  1  1=write, 0=read
  in_wdata  in  DATA_W  initiator write data
  in_ack  out  1  acknowledge to initiator
  in_rdata  out  DATA_W  read data to initiator
  in_err  out  1  timeout error to initiator
  out_req  out  1  request to target
  out_addr  out  ADDR_W  address to target
  out_cmd  out  1  command to target
  out_wdata  out  DATA_W  write data to target
  out_ack  in  1  target acknowledge
  out_rdata  in  DATA_W  target read data
  busy  out  1  1 in any state other than IDLE
  done  out  1  one-cycle pulse on RELEASE->IDLE

Function
REQ-003 FSM states SHALL be IDLE, CONNECT, ANSWER, READ, RELEASE, ERR; state register updates only when en=1.
REQ-004 IDLE: all gates closed; en & grant & in_req -> CONNECT next cycle.
REQ-005 CONNECT: out_req=in_req, out_addr=in_addr, out_cmd=in_cmd; out_wdata=in_wdata if in_cmd=1, else 0; cmd_q<=in_cmd each cycle; out_ack=1 -> ANSWER.
REQ-006 ANSWER: in_ack=out_ack, out_req=0; next READ if cmd_q=0, else RELEASE.
REQ-007 READ: in_rdata=out_rdata for exactly one cycle; -> RELEASE.
REQ-008 RELEASE: all forward gates closed; in_req=0 -> IDLE with done=1 that cycle; otherwise hold.
REQ-009 Gate controls SHALL be Moore-decoded from the state register; data paths SHALL be combinational through the gates; a closed gate drives 0.
REQ-010 Outside its state every output SHALL be 0 (in_ack, in_rdata, in_err, out_req, out_addr, out_cmd, out_wdata).
REQ-011 grant deassertion outside IDLE SHALL NOT abort a transaction.
REQ-012 Unreachable state encodings SHALL return to IDLE next cycle.

Reset
REQ-013 reset=0 at a clock edge SHALL force IDLE, clear cmd_q and timeout counter, and override en, in any state (including mid-transaction); all outputs 0 the following cycle.

Configuration
REQ-014 With XBAR_XP_TIMEOUT_EN defined: counter increments each en cycle in CONNECT with out_ack=0, clears on entry to CONNECT; reaching TMO_CYC-1 -> ERR; ERR drives in_ack=1, in_err=1, out_req=0 for one cycle, then RELEASE; out_ack=1 in the same cycle as the limit wins (-> ANSWER).
REQ-015 Without XBAR_XP_TIMEOUT_EN: no counter or ERR state; in_err tied 0; CONNECT waits indefinitely.

Structure
REQ-016 State enum, state encoding width and default widths SHALL reside in package xbar_pkg.
REQ-017 Gating SHALL be one parametrised sub-module xbar_gate (WIDTH, sel, d -> q = sel ? d : 0), instanced per bus.

Verification
REQ-018 Write: grant=1, in_req=1, in_cmd=1, addr=0x10, wdata=0xA5A5A5A5; out_ack after 3 cycles -> out_wdata=0xA5A5A5A5 in CONNECT, in_ack=1 one cycle, done after in_req=0.
REQ-019 Read: in_cmd=0, out_rdata=0x12345678 -> out_wdata=0 throughout; in_rdata=0x12345678 in READ only.
REQ-020 en=0 during CONNECT for 5 cycles -> state and outputs held; resumes on en=1.
REQ-021 reset=0 in READ -> IDLE next cycle, all outputs 0, busy=0.
REQ-022 TIMEOUT_EN, TMO_CYC=8, no out_ack -> in_err=in_ack=1 one cycle after 7 waiting cycles, then RELEASE; out_ack at cycle 7 -> ANSWER, no error.

Source files
------------

// File: rtl/xbar_pkg.sv
// xbar_pkg: shared state type, encoding width and default widths for the
// crossbar crosspoint and its gates.
package xbar_pkg;

  localparam int XBAR_ADDR_W  = 32;
  localparam int XBAR_DATA_W  = 32;
  localparam int XBAR_TMO_CYC = 64;
  localparam int XBAR_STATE_W = 3;

  typedef enum logic [XBAR_STATE_W-1:0] {
    IDLE    = 3'd0,
    CONNECT = 3'd1,
    ANSWER  = 3'd2,
    READ    = 3'd3,
    RELEASE = 3'd4,
    ERR     = 3'd5
  } xbar_state_e;

  // Width of a counter that must hold values up to cyc-1.
  function automatic int xbar_cnt_w(input int cyc);
    return (cyc > 2) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/xbar_gate.sv
// xbar_gate: a single bus gate of the crosspoint; a closed gate drives zero.
module xbar_gate #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = sel ? d : '0;

endmodule

// File: rtl/xbar_crosspoint.sv
// xbar_crosspoint: one crosspoint of a crossbar column. A Moore FSM opens the
// forward gates (request/address/command/write data) while connected, then the
// acknowledge and read-data return gates for one cycle each.
// Optional feature macro: XBAR_XP_TIMEOUT_EN adds an out_ack wait limit of
// TMO_CYC cycles and an ERR state that answers the initiator with in_err.
module xbar_crosspoint
  import xbar_pkg::*;
#(
  parameter int ADDR_W  = XBAR_ADDR_W,
  parameter int DATA_W  = XBAR_DATA_W,
  parameter int TMO_CYC = XBAR_TMO_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              grant,
  input  logic              in_req,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_cmd,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              in_ack,
  output logic [DATA_W-1:0] in_rdata,
  output logic              in_err,
  output logic              out_req,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_cmd,
  output logic [DATA_W-1:0] out_wdata,
  input  logic              out_ack,
  input  logic [DATA_W-1:0] out_rdata,
  output logic              busy,
  output logic              done
);

  xbar_state_e state_q, state_d;
  logic        cmd_q, cmd_d;
  logic        fwdOpen, ackOpen, rdOpen, errOpen, stateLegal;
  logic        ackFwd;

`ifdef XBAR_XP_TIMEOUT_EN
  localparam int              TMO_W    = xbar_cnt_w(TMO_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 2);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Next-state logic and Moore decode of the gate controls from the state register.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    fwdOpen    = 1'b0;
    ackOpen    = 1'b0;
    rdOpen     = 1'b0;
    errOpen    = 1'b0;
    stateLegal = 1'b1;
`ifdef XBAR_XP_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant && in_req) begin
          state_d = CONNECT;
`ifdef XBAR_XP_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      CONNECT: begin
        fwdOpen = 1'b1;
        cmd_d   = in_cmd;
        if (out_ack) begin
          state_d = ANSWER;
        end
`ifdef XBAR_XP_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_LAST) begin
            state_d = ERR;
          end
        end
`endif
      end
      ANSWER: begin
        ackOpen = 1'b1;
        state_d = cmd_q ? RELEASE : READ;
      end
      READ: begin
        rdOpen  = 1'b1;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!in_req) begin
          state_d = IDLE;
        end
      end
`ifdef XBAR_XP_TIMEOUT_EN
      ERR: begin
        errOpen = 1'b1;
        state_d = RELEASE;
      end
`endif
      default: begin
        stateLegal = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State register: reset wins over everything, en freezes, illegal codes recover regardless of en.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q   <= 1'b0;
`ifdef XBAR_XP_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else if (en || !stateLegal) begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
`ifdef XBAR_XP_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  xbar_gate #(.WIDTH(1)) u_gate_req (
    .sel(fwdOpen), .d(in_req), .q(out_req)
  );

  xbar_gate #(.WIDTH(ADDR_W)) u_gate_addr (
    .sel(fwdOpen), .d(in_addr), .q(out_addr)
  );

  xbar_gate #(.WIDTH(1)) u_gate_cmd (
    .sel(fwdOpen), .d(in_cmd), .q(out_cmd)
  );

  // Write data only passes for write commands so reads never leak initiator data.
  xbar_gate #(.WIDTH(DATA_W)) u_gate_wdata (
    .sel(fwdOpen & in_cmd), .d(in_wdata), .q(out_wdata)
  );

  xbar_gate #(.WIDTH(1)) u_gate_ack (
    .sel(ackOpen), .d(out_ack), .q(ackFwd)
  );

  xbar_gate #(.WIDTH(DATA_W)) u_gate_rdata (
    .sel(rdOpen), .d(out_rdata), .q(in_rdata)
  );

`ifdef XBAR_XP_TIMEOUT_EN
  assign in_ack = ackFwd | errOpen;
  assign in_err = errOpen;
`else
  // No error path in this build; TMO_CYC is always >= 2 so this is constant 0.
  assign in_ack = ackFwd | errOpen;
  assign in_err = (TMO_CYC == 0);
`endif

  assign busy = (state_q != IDLE);
  assign done = (state_q == RELEASE) && en && !in_req;

endmodule

// File: tb/tb_xbar_crosspoint.sv
// tb_xbar_crosspoint: directed scenarios plus randomized traffic, each checked
// against a transaction-level reference model of the crosspoint.
// Timeout scenarios follow XBAR_XP_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_xbar_crosspoint;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
`ifdef XBAR_XP_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int PH_IDLE    = 0;
  localparam int PH_CONNECT = 1;
  localparam int PH_ANSWER  = 2;
  localparam int PH_READ    = 3;
  localparam int PH_RELEASE = 4;
  localparam int PH_ERR     = 5;

  typedef struct packed {
    logic          inAck;
    logic [DW-1:0] inRdata;
    logic          inErr;
    logic          outReq;
    logic [AW-1:0] outAddr;
    logic          outCmd;
    logic [DW-1:0] outWdata;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset, en, grant, in_req, in_cmd, out_ack;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata, out_rdata;
  logic          in_ack, in_err, out_req, out_cmd, busy, done;
  logic [DW-1:0] in_rdata, out_wdata;
  logic [AW-1:0] out_addr;

  int nChecks = 0;
  int nFails  = 0;

  int mPhase   = PH_IDLE;
  bit mIsWrite = 1'b0;
  int mWaited  = 0;

  always #5 clk = ~clk;

  xbar_crosspoint #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .en(en), .grant(grant),
    .in_req(in_req), .in_addr(in_addr), .in_cmd(in_cmd), .in_wdata(in_wdata),
    .in_ack(in_ack), .in_rdata(in_rdata), .in_err(in_err),
    .out_req(out_req), .out_addr(out_addr), .out_cmd(out_cmd), .out_wdata(out_wdata),
    .out_ack(out_ack), .out_rdata(out_rdata), .busy(busy), .done(done)
  );

  function automatic obs_t sample();
    obs_t o;
    o.inAck = in_ack;   o.inRdata = in_rdata;  o.inErr = in_err;
    o.outReq = out_req; o.outAddr = out_addr;  o.outCmd = out_cmd;
    o.outWdata = out_wdata; o.busy = busy;     o.done = done;
    return o;
  endfunction

  // Expected outputs: what the initiator and target should see in the current phase.
  function automatic obs_t modelOut();
    obs_t e;
    e = '0;
    e.busy = (mPhase != PH_IDLE);
    case (mPhase)
      PH_CONNECT: begin
        e.outReq   = in_req;
        e.outAddr  = in_addr;
        e.outCmd   = in_cmd;
        e.outWdata = in_cmd ? in_wdata : '0;
      end
      PH_ANSWER:  e.inAck = out_ack;
      PH_READ:    e.inRdata = out_rdata;
      PH_RELEASE: e.done = en && !in_req;
      PH_ERR: begin
        e.inAck = 1'b1;
        e.inErr = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Transaction progress at a clock edge, from the inputs present at that edge.
  function automatic void modelEdge();
    if (!reset) begin
      mPhase = PH_IDLE; mWaited = 0; mIsWrite = 1'b0;
      return;
    end
    if (!en) return;
    case (mPhase)
      PH_IDLE: if (grant && in_req) begin mPhase = PH_CONNECT; mWaited = 0; end
      PH_CONNECT: begin
        mIsWrite = in_cmd;
        if (out_ack) mPhase = PH_ANSWER;
        else begin
          mWaited++;
          if (TMO_ON && mWaited == TMO - 1) mPhase = PH_ERR;
        end
      end
      PH_ANSWER:  mPhase = mIsWrite ? PH_RELEASE : PH_READ;
      PH_READ:    mPhase = PH_RELEASE;
      PH_RELEASE: if (!in_req) mPhase = PH_IDLE;
      default:    mPhase = PH_RELEASE;
    endcase
  endfunction

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setQuiet();
    reset = 1'b1; en = 1'b1; grant = 1'b0; in_req = 1'b0; in_cmd = 1'b0;
    in_addr = '0; in_wdata = '0; out_ack = 1'b0; out_rdata = '0;
  endtask

  task automatic test_reset();
    obs_t act;
    setQuiet();
    reset = 1'b0; grant = 1'b1; in_req = 1'b1; in_cmd = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom_range(0, 1)); grant = 1'($urandom_range(0, 1));
      in_req = 1'($urandom_range(0, 1)); in_cmd = 1'($urandom_range(0, 1));
      in_addr = $urandom(); in_wdata = $urandom(); out_ack = 1'($urandom_range(0, 1));
      out_rdata = $urandom();
      #1;
      act = sample();
      nChecks++;
      if (act !== '0) begin
        nFails++;
        $display("[TB] FAIL reset_state c%0d: got %h, want 0", i, act);
      end
      tick();
    end
    setQuiet();
    tick();
  endtask

  task automatic test_write();
    obs_t act, exp;
    logic [8:0] reqSeq, ackSeq;
    int ackCnt, doneCnt, wdataCnt;
    reqSeq = 9'b001111111; ackSeq = 9'b000110000;
    ackCnt = 0; doneCnt = 0; wdataCnt = 0;
    setQuiet();
    grant = 1'b1; in_cmd = 1'b1; in_addr = 32'h10; in_wdata = 32'hA5A5A5A5;
    for (int i = 0; i < 9; i++) begin
      in_req = reqSeq[i]; out_ack = ackSeq[i];
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL write c%0d: got %h, want %h", i, act, exp);
      end
      if (in_ack) ackCnt++;
      if (done) doneCnt++;
      if (out_wdata == 32'hA5A5A5A5 && out_addr == 32'h10 && out_req) wdataCnt++;
      tick();
    end
    nChecks++;
    if (ackCnt != 1) begin nFails++; $display("[TB] FAIL write_ack_cycles: got %0d, want 1", ackCnt); end
    nChecks++;
    if (doneCnt != 1) begin nFails++; $display("[TB] FAIL write_done_cycles: got %0d, want 1", doneCnt); end
    nChecks++;
    if (wdataCnt != 4) begin nFails++; $display("[TB] FAIL write_fwd_cycles: got %0d, want 4", wdataCnt); end
  endtask

  task automatic test_read();
    obs_t act, exp;
    logic [8:0] reqSeq, ackSeq;
    int rdCnt, wdCnt, doneCnt;
    reqSeq = 9'b001111111; ackSeq = 9'b000110000;
    rdCnt = 0; wdCnt = 0; doneCnt = 0;
    setQuiet();
    grant = 1'b1; in_cmd = 1'b0; in_addr = 32'h20; in_wdata = 32'hDEADBEEF;
    out_rdata = 32'h12345678;
    for (int i = 0; i < 9; i++) begin
      in_req = reqSeq[i]; out_ack = ackSeq[i];
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL read c%0d: got %h, want %h", i, act, exp);
      end
      if (in_rdata == 32'h12345678) rdCnt++;
      if (out_wdata != '0) wdCnt++;
      if (done) doneCnt++;
      tick();
    end
    nChecks++;
    if (rdCnt != 1) begin nFails++; $display("[TB] FAIL read_rdata_cycles: got %0d, want 1", rdCnt); end
    nChecks++;
    if (wdCnt != 0) begin nFails++; $display("[TB] FAIL read_wdata_leak: got %0d, want 0", wdCnt); end
    nChecks++;
    if (doneCnt != 1) begin nFails++; $display("[TB] FAIL read_done_cycles: got %0d, want 1", doneCnt); end
  endtask

  task automatic test_enable_hold();
    obs_t act, exp;
    int holdCnt, cyc;
    holdCnt = 0;
    setQuiet();
    grant = 1'b1; in_req = 1'b1; in_cmd = 1'b1; in_addr = $urandom(); in_wdata = $urandom();
    tick();
    for (int i = 0; i < 7; i++) begin
      en = (i >= 5); out_ack = 1'b1;
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL enable_hold c%0d: got %h, want %h", i, act, exp);
      end
      if (i < 5 && busy && out_req && out_wdata == in_wdata) holdCnt++;
      tick();
    end
    nChecks++;
    if (holdCnt != 5) begin nFails++; $display("[TB] FAIL enable_hold_connect: got %0d, want 5", holdCnt); end
    in_req = 1'b0; out_ack = 1'b0;
    cyc = 0;
    while (busy && cyc < 10) begin
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL enable_resume c%0d: got %h, want %h", cyc, act, exp);
      end
      tick();
      cyc++;
    end
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL enable_resume_idle: busy got %b, want 0", busy); end
  endtask

  task automatic test_reset_mid();
    obs_t act, exp;
    logic [2:0] ackSeq;
    ackSeq = 3'b010;
    setQuiet();
    grant = 1'b1; in_req = 1'b1; in_cmd = 1'b0; out_rdata = $urandom() | 32'h1;
    for (int i = 0; i < 4; i++) begin
      out_ack = (i < 3) ? ackSeq[i] : 1'b0;
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL reset_mid c%0d: got %h, want %h", i, act, exp);
      end
      if (i == 3) begin
        nChecks++;
        if (in_rdata !== out_rdata) begin
          nFails++;
          $display("[TB] FAIL reset_mid_read: got %h, want %h", in_rdata, out_rdata);
        end
        reset = 1'b0;
      end
      tick();
    end
    reset = 1'b1;
    #1;
    act = sample();
    nChecks++;
    if (act !== '0) begin nFails++; $display("[TB] FAIL reset_mid_idle: got %h, want 0", act); end
    in_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    obs_t act, exp;
    int errCnt, firstErr, ackCnt;
`ifdef XBAR_XP_TIMEOUT_EN
    for (int s = 0; s < 2; s++) begin
      errCnt = 0; firstErr = -1; ackCnt = 0;
      setQuiet();
      grant = 1'b1; in_cmd = 1'b1; in_wdata = $urandom();
      for (int i = 0; i < 12; i++) begin
        in_req = (i < 10);
        out_ack = (s == 1) && (i == 7 || i == 8);
        #1;
        exp = modelOut(); act = sample();
        nChecks++;
        if (act !== exp) begin
          nFails++;
          $display("[TB] FAIL timeout s%0d c%0d: got %h, want %h", s, i, act, exp);
        end
        if (in_err) begin errCnt++; if (firstErr < 0) firstErr = i; end
        if (in_ack) ackCnt++;
        tick();
      end
      nChecks++;
      if (errCnt != (s == 0 ? 1 : 0)) begin
        nFails++;
        $display("[TB] FAIL timeout_err_cycles s%0d: got %0d, want %0d", s, errCnt, (s == 0 ? 1 : 0));
      end
      nChecks++;
      if (s == 0 && firstErr != 8) begin
        nFails++;
        $display("[TB] FAIL timeout_err_time: got %0d, want 8", firstErr);
      end
      nChecks++;
      if (ackCnt != 1) begin nFails++; $display("[TB] FAIL timeout_ack_cycles s%0d: got %0d, want 1", s, ackCnt); end
    end
`else
    errCnt = 0; firstErr = 0; ackCnt = 0;
    setQuiet();
    grant = 1'b1; in_req = 1'b1; in_cmd = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL no_timeout c%0d: got %h, want %h", i, act, exp);
      end
      if (busy && out_req && !in_err && !in_ack) firstErr++;
      tick();
    end
    nChecks++;
    if (firstErr != 30) begin nFails++; $display("[TB] FAIL no_timeout_wait: got %0d, want 30", firstErr); end
    out_ack = 1'b1; tick();
    out_ack = 1'b0; in_req = 1'b0; tick();
    tick();
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL no_timeout_finish: busy got %b, want 0", busy); end
`endif
    setQuiet();
    tick();
  endtask

  task automatic test_random();
    obs_t act, exp;
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 9) != 0);
      grant     = ($urandom_range(0, 3) != 0);
      in_req    = ($urandom_range(0, 9) < 7);
      in_cmd    = 1'($urandom_range(0, 1));
      in_addr   = $urandom();
      in_wdata  = $urandom();
      out_ack   = ($urandom_range(0, 9) < 2);
      out_rdata = $urandom();
      #1;
      exp = modelOut(); act = sample();
      nChecks++;
      if (act !== exp) begin
        nFails++;
        $display("[TB] FAIL random c%0d: got %h, want %h", i, act, exp);
      end
      tick();
    end
  endtask

  initial begin
    $display("[TB] crosspoint bench start, timeout feature %0d", TMO_ON);
    test_reset();
    test_write();
    test_read();
    test_enable_hold();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
